// File: rtl/filtered_trace_serializer.sv
// filtered_trace_serializer: queues filtered trace elements and emits each one as a header/stage-end/payload word frame.
// Define GOURAM_SERIALIZER_TIMESTAMP_EN to store the write-time counter per entry and send it after the stage-end word.
module filtered_trace_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TRACE_WIDTH = 96,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            counter,
  input  logic [TRACE_WIDTH-1:0] filtered_data,
  input  logic [31:0]            if_stage_end_i,
  input  logic                   filtered_data_ready,
  output logic [DATA_WIDTH-1:0]  word_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic                   word_last_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NP = (TRACE_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int BW = NP > 1 ? $clog2(NP) : 1;
`ifdef GOURAM_SERIALIZER_TIMESTAMP_EN
  localparam int EW = TRACE_WIDTH + 64;
  localparam int NW = NP + 3;
`else
  localparam int EW = TRACE_WIDTH + 32;
  localparam int NW = NP + 2;
`endif
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] HEADER    = 3'd1;
  localparam logic [2:0] STAGE_END = 3'd2;
`ifdef GOURAM_SERIALIZER_TIMESTAMP_EN
  localparam logic [2:0] TIMESTAMP = 3'd3;
`endif
  localparam logic [2:0] PAYLOAD   = 3'd4;

  logic [2:0]     state = IDLE;
  logic [2:0]     state_nx;
  logic [AW:0]    wr_ptr = '0;
  logic [AW:0]    rd_ptr = '0;
  logic [AW:0]    cnt;
  logic [7:0]     seq = '0;
  logic [7:0]     drop_cnt = '0;
  logic [BW-1:0]  beat = '0;
  logic [EW-1:0]  mem [FIFO_DEPTH];
  logic [EW-1:0]  entry;
  logic [EW-1:0]  head;
  logic [NP*32-1:0] pad;
  logic full, empty, push, drop, hdr_acc, last, pop, more;

`ifdef GOURAM_SERIALIZER_TIMESTAMP_EN
  assign entry = {counter, filtered_data, if_stage_end_i};
`else
  logic unused_counter;
  assign unused_counter = ^counter;
  assign entry = {filtered_data, if_stage_end_i};
`endif
  assign cnt = wr_ptr - rd_ptr;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign push = rst_n && filtered_data_ready && !full;
  assign drop = filtered_data_ready && full;
  assign head = mem[rd_ptr[AW-1:0]];
  assign pad = (NP*32)'(head[TRACE_WIDTH+31:32]);
  assign hdr_acc = state == HEADER && word_ready_i;
  assign last = state == PAYLOAD && beat == BW'(NP - 1);
  assign pop = last && word_ready_i;
  // a same-edge write keeps the frame train going straight into the next header
  assign more = cnt != (AW+1)'(1) || push;

  assign state_nx = state == IDLE ? (empty ? IDLE : HEADER)
                  : !word_ready_i ? state
                  : state == HEADER ? STAGE_END
`ifdef GOURAM_SERIALIZER_TIMESTAMP_EN
                  : state == STAGE_END ? TIMESTAMP
                  : state == TIMESTAMP ? PAYLOAD
`else
                  : state == STAGE_END ? PAYLOAD
`endif
                  : !last ? PAYLOAD
                  : more ? HEADER : IDLE;

  // header drop field is live so drops during a header stall are still reported
  assign word_o = state == HEADER ? {8'hA5, seq, 8'(NW), drop_cnt}
                : state == STAGE_END ? head[31:0]
`ifdef GOURAM_SERIALIZER_TIMESTAMP_EN
                : state == TIMESTAMP ? head[EW-1 -: 32]
`endif
                : state == PAYLOAD ? pad[32*beat +: 32]
                : '0;
  assign word_valid_o = state != IDLE;
  assign word_last_o = last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      seq <= '0;
      drop_cnt <= '0;
      beat <= '0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (hdr_acc) seq <= seq + 8'd1;
      drop_cnt <= hdr_acc ? {7'd0, drop} : (drop && drop_cnt != 8'hFF) ? drop_cnt + 8'd1 : drop_cnt;
      if (state == PAYLOAD && word_ready_i) beat <= last ? '0 : beat + BW'(1);
    end
  end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
endmodule

// File: doc/filtered_trace_serializer.md
FILTERED_TRACE_SERIALIZER -- requirements
Module: filtered_trace_serializer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, frame-queue entries, power of two, at least 2.
REQ-002 SHALL have parameter TRACE_WIDTH, default 96, filtered trace element width in bits.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, output word width; only 32 supported.
REQ-004 SHALL have port clk, input, 1, clock; reset rst_n, synchronous, active-low.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port counter, input, 32, free-running cycle count.
REQ-007 SHALL have port filtered_data, input, TRACE_WIDTH, trace element from the validity filter.
REQ-008 SHALL have port if_stage_end_i, input, 32, IF end time paired with filtered_data.
REQ-009 SHALL have port filtered_data_ready, input, 1, one-cycle pulse marking filtered_data/if_stage_end_i valid.
REQ-010 SHALL have port word_o, output, 32, serialized frame word.
REQ-011 SHALL have port word_valid_o, output, 1, word_o valid.
REQ-012 SHALL have port word_ready_i, input, 1, sink accepts word_o.
REQ-013 SHALL have port word_last_o, output, 1, word_o is final word of frame.

Function
REQ-014 SHALL write {filtered_data, if_stage_end_i} to FIFO on the clk edge where filtered_data_ready=1 and FIFO not full.
REQ-015 SHALL, when FIFO full at that edge, drop the element, increment 8-bit drop count saturating at 255; fullness evaluated before any same-edge pop.
REQ-016 SHALL implement FSM IDLE -> HEADER -> STAGE_END -> PAYLOAD -> IDLE (TIMESTAMP between STAGE_END and PAYLOAD when REQ-031 enabled).
REQ-017 SHALL leave IDLE for HEADER on the first edge FIFO is non-empty; element written at edge N gives word_valid_o=1 after edge N+1.
REQ-018 SHALL advance a word only on an edge with word_valid_o=1 and word_ready_i=1; word_o, word_last_o stable while valid and not ready.
REQ-019 SHALL keep word_valid_o=1 continuously from HEADER until last payload word accepted; never deassert mid-frame.
REQ-020 SHALL form header as [31:24]=0xA5, [23:16]=sequence number, [15:8]=total frame words incl. header, [7:0]=drop count.
REQ-021 SHALL increment sequence number on each header acceptance, wrapping 255 to 0; first frame after reset uses 0.
REQ-022 SHALL clear drop count on header acceptance; a drop on that same edge leaves count 1.
REQ-023 SHALL send STAGE_END word = stored if_stage_end_i.
REQ-024 SHALL send ceil(TRACE_WIDTH/32) payload words, least significant slice first, final word zero-padded above TRACE_WIDTH.
REQ-025 SHALL assert word_last_o only on final payload word; pop FIFO on its acceptance; return to IDLE, or HEADER directly if FIFO still non-empty.
REQ-026 SHALL accept FIFO writes in every FSM state, including while stalled.

Reset
REQ-027 SHALL, with rst_n=0 at an edge, set word_valid_o=0, word_last_o=0, word_o=0, FSM IDLE, FIFO empty, sequence 0, drop count 0.
REQ-028 SHALL abandon any partial frame on reset mid-frame; no resumption after release.
REQ-029 SHALL ignore filtered_data_ready at an edge where rst_n=0.
REQ-030 SHALL hold initial-block values equal to reset values for simulation without reset.

Configuration
REQ-031 SHALL, with GOURAM_SERIALIZER_TIMESTAMP_EN defined, store counter at write time per entry and emit it as a TIMESTAMP word after STAGE_END; frame count field includes it (6 at default).
REQ-032 SHALL, without GOURAM_SERIALIZER_TIMESTAMP_EN, omit timestamp storage and state; frame is 5 words at default.

Verification
REQ-033 SHALL cover: one pulse, data=0x..._CCCCCCCC_BBBBBBBB_AAAAAAAA, stage end 0x10, ready held 1 -> 0xA5000500, 0x10, 0xAAAAAAAA, 0xBBBBBBBB, 0xCCCCCCCC, last on fifth.
REQ-034 SHALL cover: ready low 3 cycles during STAGE_END -> word_o=stage end and valid stable throughout, no word lost.
REQ-035 SHALL cover: 6 pulses while ready=0, depth 4 -> 4 frames out, first header [7:0]=2, sequences 0..3.
REQ-036 SHALL cover: pulse on the final payload acceptance edge with FIFO full -> dropped, next header drop count 1.
REQ-037 SHALL cover: rst_n low during PAYLOAD, then new pulse -> valid low after reset, next header 0xA5000500.
REQ-038 SHALL cover: TIMESTAMP_EN, pulse at counter 0x64 -> header 0xA5000600, third word 0x64.
